// File: rtl/lab_compose_if.sv
// rtl/lab_compose_if.sv - pixel handshake bundle between cube-root stages, Lab composer and sink
interface lab_compose_if #(
    parameter int DSIZE = 16
);
    logic [DSIZE-1:0] fx;
    logic [DSIZE-1:0] fy;
    logic [DSIZE-1:0] fz;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       L_out;
    logic [7:0]       a_out;
    logic [7:0]       b_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output fx, fy, fz, in_valid, out_ready,
        input  in_ready, L_out, a_out, b_out, out_valid
    );

    modport slave (
        input  fx, fy, fz, in_valid, out_ready,
        output in_ready, L_out, a_out, b_out, out_valid
    );
endinterface

// File: rtl/lab_compose.sv
// rtl/lab_compose.sv - three-stage f(X)/f(Y)/f(Z) to CIE L*a*b* composer with global stall
module lab_compose #(
    parameter int DSIZE = 16
) (
    input  logic          clock,
    input  logic          rst,
    lab_compose_if.slave  bus
);
    localparam int SW = DSIZE + 1;
    localparam int PW = DSIZE + 10;
    localparam int RW = PW - DSIZE;

    localparam logic signed [PW-1:0] K_L   = PW'(116);
    localparam logic signed [PW-1:0] K_A   = PW'(500);
    localparam logic signed [PW-1:0] K_B   = PW'(200);
    localparam logic signed [PW-1:0] L_OFF = {6'b000001, {(DSIZE+4){1'b0}}};
    localparam logic signed [PW-1:0] HALF  = {{(PW-DSIZE){1'b0}}, 1'b1, {(DSIZE-1){1'b0}}};

    logic stall;
    logic v1, v2, v3;
    logic signed [SW-1:0] s1_fy, s1_dxy, s1_dyz;
    logic signed [PW-1:0] p_l, p_a, p_b;
    logic signed [RW-1:0] r_l, r_a, r_b;
    logic [7:0] l_q, a_q, b_q;

    // A held output freezes the whole pipeline; nothing is compressed into bubbles.
    assign stall         = v3 && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = v3;
    assign bus.L_out     = l_q;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;

    function automatic logic [7:0] clamp_l(input logic signed [RW-1:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > 10'sd100)
            return 8'd100;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] clamp_ab(input logic signed [RW-1:0] v);
        if (v < -10'sd128)
            return 8'h80;
        else if (v > 10'sd127)
            return 8'h7f;
        else
            return v[7:0];
    endfunction

    // Round half-up: add one half LSB of the result, then drop DSIZE fraction bits arithmetically.
    always_comb begin
        r_l = RW'((p_l + HALF) >>> DSIZE);
        r_a = RW'((p_a + HALF) >>> DSIZE);
        r_b = RW'((p_b + HALF) >>> DSIZE);
    end

    // Stage 1: signed differences of the cube-root inputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            s1_fy  <= '0;
            s1_dxy <= '0;
            s1_dyz <= '0;
        end else if (!stall) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fy  <= $signed({1'b0, bus.fy});
                s1_dxy <= $signed({1'b0, bus.fx}) - $signed({1'b0, bus.fy});
                s1_dyz <= $signed({1'b0, bus.fy}) - $signed({1'b0, bus.fz});
            end
        end
    end

    // Stage 2: full-width scaled products, no truncation.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            p_l <= '0;
            p_a <= '0;
            p_b <= '0;
        end else if (!stall) begin
            v2 <= v1;
            if (v1) begin
                p_l <= PW'(s1_fy) * K_L - L_OFF;
                p_a <= PW'(s1_dxy) * K_A;
                p_b <= PW'(s1_dyz) * K_B;
            end
        end
    end

    // Stage 3: clamp the rounded values into the 8-bit output ranges; data holds across bubbles.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v3  <= 1'b0;
            l_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (!stall) begin
            v3 <= v2;
            if (v2) begin
                l_q <= clamp_l(r_l);
                a_q <= clamp_ab(r_a);
                b_q <= clamp_ab(r_b);
            end
        end
    end
endmodule

// File: tb/tb_lab_compose.sv
// tb/tb_lab_compose.sv - self-checking bench for lab_compose with reference model and scoreboard
module tb_lab_compose;
    logic clock = 1'b0;
    logic rst   = 1'b1;

    lab_compose_if #(.DSIZE(16)) bus ();

    lab_compose #(.DSIZE(16)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          emitted = 0;
    int          accepted = 0;
    int          stalls = 0;
    bit          last_acc = 1'b0;
    bit          prev_stall = 1'b0;
    logic [23:0] held = '0;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic logic [23:0] model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        longint l, a, b;
        l = fdiv(116 * longint'(y) - 16 * 65536 + 32768, 65536);
        a = fdiv(500 * (longint'(x) - longint'(y)) + 32768, 65536);
        b = fdiv(200 * (longint'(y) - longint'(z)) + 32768, 65536);
        if (l < 0) l = 0;
        if (l > 100) l = 100;
        if (a < -128) a = -128;
        if (a > 127) a = 127;
        if (b < -128) b = -128;
        if (b > 127) b = 127;
        return {8'(l), 8'(a), 8'(b)};
    endfunction

    // One handshake cycle: drive at the falling edge, judge what the next rising edge will do.
    task automatic step(input logic iv, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic ordy, input bit wait_edge);
        logic [23:0] e;
        if (wait_edge)
            @(negedge clock);
        bus.in_valid  = iv;
        bus.fx        = x;
        bus.fy        = y;
        bus.fz        = z;
        bus.out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'({bus.L_out, bus.a_out, bus.b_out}), 32'(held));
        end
        chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !ordy)));
        last_acc = iv && bus.in_ready;
        if (bus.out_valid && ordy) begin
            emitted++;
            chk("emit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("L_out", 32'(bus.L_out), 32'(e[23:16]));
                chk("a_out", 32'(bus.a_out), 32'(e[15:8]));
                chk("b_out", 32'(bus.b_out), 32'(e[7:0]));
            end
        end
        if (last_acc) begin
            exp_q.push_back(model(x, y, z));
            accepted++;
        end
        prev_stall = bus.out_valid && !ordy;
        if (prev_stall)
            stalls++;
        held = {bus.L_out, bus.a_out, bus.b_out};
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [7:0] el, input logic [7:0] ea,
                            input logic [7:0] eb);
        step(1'b1, x, y, z, 1'b1, 1'b1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_L"}, 32'(bus.L_out), 32'(el));
        chk({tag, "_a"}, 32'(bus.a_out), 32'(ea));
        chk({tag, "_b"}, 32'(bus.b_out), 32'(eb));
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [15:0] px[8];
        int sent;
        int cyc;

        bus.in_valid  = 1'b0;
        bus.fx        = '0;
        bus.fy        = '0;
        bus.fz        = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_data", 32'({bus.L_out, bus.a_out, bus.b_out}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;

        directed("mid",     16'hC000, 16'h8000, 16'h4000, 8'd42,  8'd125, 8'd50);
        directed("black",   16'h0000, 16'h0000, 16'h0000, 8'd0,   8'd0,   8'd0);
        directed("white",   16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd100, 8'd0,   8'd0);
        directed("sat",     16'hFFFF, 16'h0000, 16'hFFFF, 8'd0,   8'h7F,  8'h80);
        directed("rnd_neg", 16'h0000, 16'h0100, 16'h0100, 8'd0,   8'hFE,  8'd0);

        // Eight distinct pixels with the sink refusing on cycles 5..7.
        for (int i = 0; i < 8; i++)
            px[i] = 16'(16'h1F00 * i + 16'h0123);
        emitted = 0;
        stalls  = 0;
        sent    = 0;
        for (int c = 0; c < 24; c++) begin
            if (sent < 8)
                step(1'b1, px[sent], px[7 - sent], 16'(px[sent] ^ 16'h5A5A), !(c >= 5 && c <= 7), 1'b1);
            else
                step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
            if (last_acc)
                sent++;
        end
        chk("bp_emitted", 32'(emitted), 32'd8);
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with one pixel stalled at the output and one behind it.
        step(1'b1, 16'h1234, 16'h4321, 16'h0F0F, 1'b0, 1'b1);
        step(1'b1, 16'hABCD, 16'h2222, 16'h9999, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_data", 32'({bus.L_out, bus.a_out, bus.b_out}), 32'd0);
        chk("rst_async_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        #1;
        rst = 1'b0;
        emitted = 0;
        step(1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0);
        chk("post_rst_accept", 32'(last_acc), 32'd1);
        for (int i = 0; i < 6; i++)
            step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("post_rst_emitted", 32'(emitted), 32'd1);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic against the reference model.
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 60000) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'b1);
            cyc++;
        end
        chk("rand_accepted", 32'(accepted), 32'd10000);
        for (int i = 0; i < 8; i++)
            step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
